// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : 8N1 UART receiver with 2-flop input synchronizer, mid-bit
//               sampling FSM, first-word fall-through receive FIFO and
//               sticky framing / overrun error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver #(
   parameter int clk_freq_hz = 12000000,
   parameter int baud_rate   = 9600,
   parameter int fifo_depth  = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_uart_rx,
   output logic [7:0]                    o_data,
   output logic                          o_valid,
   input  logic                          i_ready,
   input  logic                          i_clr_err,
   output logic                          o_frame_err,
   output logic                          o_overrun,
   output logic                          o_busy,
   output logic [$clog2(fifo_depth):0]   o_count
);

   localparam int DIV  = clk_freq_hz / baud_rate;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV + 1);
   localparam int AW   = $clog2(fifo_depth);

   localparam logic [CW-1:0] DIV_L  = CW'(DIV);
   localparam logic [CW-1:0] HALF_L = CW'(HALF);
   localparam logic [CW-1:0] CNT_1  = CW'(1);
   localparam logic [AW:0]   FULL_L = (AW + 1)'(fifo_depth);
   localparam logic [AW:0]   OCC_1  = (AW + 1)'(1);
   localparam logic [AW-1:0] PTR_1  = AW'(1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   state_t          state, state_next;
   logic            sync1, rx_s;
   logic [CW-1:0]   cnt, cnt_next;
   logic [2:0]      bit_idx, bit_next;
   logic [7:0]      shreg, shreg_next;
   logic            push, frame_set, sample;

   logic [7:0]      mem [fifo_depth];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic            full, pop, wr_en, overrun_set;

   // Two-flop synchronizer; flops reset to the idle-high line level
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= i_uart_rx;
         rx_s  <= sync1;
      end
   end

   // Receive FSM state, baud counter, bit index and shift register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         bit_idx <= bit_next;
         shreg   <= shreg_next;
      end
   end

   // Next-state logic; the counter counts down and a sample is taken when it reaches 1
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      bit_next   = bit_idx;
      shreg_next = shreg;
      push       = 1'b0;
      frame_set  = 1'b0;
      sample     = (cnt == CNT_1);
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_next = START;
               cnt_next   = HALF_L;
            end
         end
         START: begin
            if (sample) begin
               if (!rx_s) begin
                  state_next = DATA;
                  cnt_next   = DIV_L;
                  bit_next   = 3'd0;
               end else begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end
            end else begin
               cnt_next = cnt - CNT_1;
            end
         end
         DATA: begin
            if (sample) begin
               shreg_next = {rx_s, shreg[7:1]};
               cnt_next   = DIV_L;
               if (bit_idx == 3'd7) begin
                  state_next = STOP;
               end else begin
                  bit_next = bit_idx + 3'd1;
               end
            end else begin
               cnt_next = cnt - CNT_1;
            end
         end
         STOP: begin
            if (sample) begin
               cnt_next = '0;
               if (rx_s) begin
                  push       = 1'b1;
                  state_next = IDLE;
               end else begin
                  frame_set  = 1'b1;
                  state_next = WAIT_HIGH;
               end
            end else begin
               cnt_next = cnt - CNT_1;
            end
         end
         WAIT_HIGH: begin
            if (rx_s) state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   assign full        = (count == FULL_L);
   assign pop         = o_valid && i_ready;
   assign wr_en       = push && (!full || pop);
   assign overrun_set = push && full && !pop;

   // FIFO storage and pointers; a push into a full FIFO is accepted only alongside a pop
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < fifo_depth; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= shreg;
            wr_ptr      <= wr_ptr + PTR_1;
         end
         if (pop) rd_ptr <= rd_ptr + PTR_1;
         case ({wr_en, pop})
            2'b10:   count <= count + OCC_1;
            2'b01:   count <= count - OCC_1;
            default: count <= count;
         endcase
      end
   end

   // Sticky error flags; a set event wins over a simultaneous clear
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
      end else begin
         if (frame_set)      o_frame_err <= 1'b1;
         else if (i_clr_err) o_frame_err <= 1'b0;
         if (overrun_set)    o_overrun   <= 1'b1;
         else if (i_clr_err) o_overrun   <= 1'b0;
      end
   end

   assign o_data  = mem[rd_ptr];
   assign o_valid = (count != '0);
   assign o_count = count;
   assign o_busy  = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_receiver
// Description : Directed self-checking bench for uart_receiver (DIV=16, HALF=8)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

   logic       clk = 1'b0;
   logic       rst;
   logic       uart_rx;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       clr_err;
   logic       frame_err;
   logic       overrun;
   logic       busy;
   logic [2:0] count;

   int pass_cnt = 0;
   int total    = 0;

   uart_receiver #(
      .clk_freq_hz (160),
      .baud_rate   (10),
      .fifo_depth  (4)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_uart_rx   (uart_rx),
      .o_data      (data),
      .o_valid     (valid),
      .i_ready     (ready),
      .i_clr_err   (clr_err),
      .o_frame_err (frame_err),
      .o_overrun   (overrun),
      .o_busy      (busy),
      .o_count     (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
   endtask

   // Step past the next rising edge; outputs are sampled 1 ns after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive steps n0..n1-1 of a 160-step 8N1 frame (16 steps per bit).
   // With rdy set, i_ready is high only for the edge that takes the stop sample.
   task automatic send(input logic [7:0] b, input logic stop, input logic rdy,
                       input int n0, input int n1);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int n = n0; n < n1; n++) begin
         uart_rx = fr[n/16];
         ready   = rdy && (n == 154);
         tick();
      end
      ready = 1'b0;
   endtask

   task automatic frame(input logic [7:0] b);
      send(b, 1'b1, 1'b0, 0, 160);
      uart_rx = 1'b1;
      tick();
      tick();
   endtask

   task automatic pop(input string tag, input logic [7:0] exp);
      check({tag, "_valid"}, 32'(valid), 32'd1);
      check({tag, "_data"}, 32'(data), 32'(exp));
      ready = 1'b1;
      tick();
      ready = 1'b0;
   endtask

   initial begin
      rst     = 1'b1;
      uart_rx = 1'b1;
      ready   = 1'b0;
      clr_err = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Reset state
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_data", 32'(data), 32'h00);
      check("rst_count", 32'(count), 32'd0);
      check("rst_ferr", 32'(frame_err), 32'd0);
      check("rst_ovr", 32'(overrun), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      // Frame 0x55: nothing before the stop-sample edge, byte visible right after it
      send(8'h55, 1'b1, 1'b0, 0, 154);
      check("f55_pre_valid", 32'(valid), 32'd0);
      check("f55_pre_busy", 32'(busy), 32'd1);
      send(8'h55, 1'b1, 1'b0, 154, 155);
      check("f55_valid", 32'(valid), 32'd1);
      check("f55_busy", 32'(busy), 32'd0);
      send(8'h55, 1'b1, 1'b0, 155, 160);
      check("f55_data", 32'(data), 32'h55);
      check("f55_count", 32'(count), 32'd1);
      check("f55_ferr", 32'(frame_err), 32'd0);
      check("f55_ovr", 32'(overrun), 32'd0);
      pop("f55_pop", 8'h55);
      check("f55_empty", 32'(valid), 32'd0);

      // 4-cycle glitch rejected by the start-bit check
      uart_rx = 1'b0;
      repeat (4) tick();
      uart_rx = 1'b1;
      repeat (2) tick();
      check("glitch_busy_mid", 32'(busy), 32'd1);
      repeat (20) tick();
      check("glitch_busy", 32'(busy), 32'd0);
      check("glitch_count", 32'(count), 32'd0);
      check("glitch_ferr", 32'(frame_err), 32'd0);

      // Framing error followed by a 40-cycle break
      send(8'hA3, 1'b0, 1'b0, 0, 160);
      check("ferr_set", 32'(frame_err), 32'd1);
      uart_rx = 1'b0;
      repeat (40) tick();
      check("ferr_wait_busy", 32'(busy), 32'd1);
      check("ferr_count", 32'(count), 32'd0);
      uart_rx = 1'b1;
      repeat (5) tick();
      check("ferr_idle_busy", 32'(busy), 32'd0);
      check("ferr_sticky", 32'(frame_err), 32'd1);
      check("ferr_no_push", 32'(count), 32'd0);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("ferr_cleared", 32'(frame_err), 32'd0);

      // Five frames with no consumer: fifth dropped, overrun set
      for (int i = 1; i <= 5; i++) frame(8'(i));
      check("ovr_count", 32'(count), 32'd4);
      check("ovr_flag", 32'(overrun), 32'd1);
      check("ovr_ferr", 32'(frame_err), 32'd0);
      pop("ovr_d1", 8'h01);
      pop("ovr_d2", 8'h02);
      pop("ovr_d3", 8'h03);
      pop("ovr_d4", 8'h04);
      check("ovr_empty", 32'(valid), 32'd0);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("ovr_cleared", 32'(overrun), 32'd0);

      // Full FIFO with push and pop on the same edge
      for (int i = 1; i <= 4; i++) frame(8'(i));
      check("pp_full_count", 32'(count), 32'd4);
      send(8'h05, 1'b1, 1'b1, 0, 160);
      uart_rx = 1'b1;
      tick();
      check("pp_count", 32'(count), 32'd4);
      check("pp_ovr", 32'(overrun), 32'd0);
      pop("pp_d2", 8'h02);
      pop("pp_d3", 8'h03);
      pop("pp_d4", 8'h04);
      pop("pp_d5", 8'h05);
      check("pp_empty", 32'(valid), 32'd0);

      // Reset in the middle of frame 0x7E, then a clean 0x3C
      send(8'h7E, 1'b1, 1'b0, 0, 60);
      rst = 1'b1;
      tick();
      tick();
      uart_rx = 1'b1;
      rst = 1'b0;
      repeat (20) tick();
      check("mrst_count", 32'(count), 32'd0);
      check("mrst_valid", 32'(valid), 32'd0);
      check("mrst_busy", 32'(busy), 32'd0);
      frame(8'h3C);
      check("mrst_rx_count", 32'(count), 32'd1);
      pop("mrst_rx", 8'h3C);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
`default_nettype wire
